// File: rtl/touch_sample_ctrl.sv
// touch_sample_ctrl: debounces the pen, paces ADC conversion frames, drops the
// first frame after each press and averages 2^AVG_LOG2 kept frames into an
// X/Y result presented on a valid/ready handshake.
module touch_sample_ctrl #(
    parameter int SYSCLK_FRQ  = 50000000,
    parameter int DEB_CNT     = 50000,
    parameter int GAP_CNT     = 500000,
    parameter int TIMEOUT_CNT = 200000,
    parameter int AVG_LOG2    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PENIRQ_n,
    input  logic        FRAME_DONE,
    input  logic [11:0] X_IN,
    input  logic [11:0] Y_IN,
    output logic        ADC_START_n,
    output logic        PEN_DOWN,
    output logic [11:0] X_OUT,
    output logic [11:0] Y_OUT,
    output logic        COORD_VALID,
    input  logic        COORD_READY,
    output logic        OVERRUN,
    output logic        TIMEOUT_ERR
);

    localparam int MAX_AB  = (DEB_CNT > GAP_CNT) ? DEB_CNT : GAP_CNT;
    localparam int CNT_MAX = (MAX_AB > TIMEOUT_CNT) ? MAX_AB : TIMEOUT_CNT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(DEB_CNT + 1);
    localparam int AW      = 12 + AVG_LOG2;
    localparam int FW      = AVG_LOG2 + 1;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CNT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CNT - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CNT - 1);
    localparam logic [RW-1:0] REL_LAST = RW'(DEB_CNT - 1);
    localparam logic [FW-1:0] FRM_FULL = FW'(2 ** AVG_LOG2);

    // The clock frequency is informational only; every count is in cycles.
    if (SYSCLK_FRQ <= 0) begin : g_no_clk_frq
    end

    typedef enum logic [1:0] {IDLE, DEBOUNCE, START, GAP} state_t;

    logic              pen_meta_reg, pen_s_reg;
    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [RW-1:0]     rel_cnt_reg, rel_cnt_next;
    logic              discard_reg, discard_next;
    logic              adc_start_n_reg, adc_start_n_next;
    logic              pen_down_reg, pen_down_next;
    logic              timeout_err_reg;
    logic              timeout_hit, keep_sample, clear_acc, release_hit;
    logic [AW-1:0]     acc_x_reg, acc_y_reg;
    logic [FW-1:0]     frm_cnt_reg;
    logic              frm_full;
    logic [11:0]       x_out_reg, y_out_reg;
    logic              valid_reg, overrun_reg;

    // Two-flop synchronizer for the asynchronous pen interrupt (idles high).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pen_meta_reg <= 1'b1;
            pen_s_reg    <= 1'b1;
        end else begin
            pen_meta_reg <= PENIRQ_n;
            pen_s_reg    <= pen_meta_reg;
        end
    end

    // Sequencer state, shared cycle counter and registered control outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            rel_cnt_reg     <= '0;
            discard_reg     <= 1'b0;
            adc_start_n_reg <= 1'b1;
            pen_down_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            rel_cnt_reg     <= rel_cnt_next;
            discard_reg     <= discard_next;
            adc_start_n_reg <= adc_start_n_next;
            pen_down_reg    <= pen_down_next;
            timeout_err_reg <= timeout_hit;
        end
    end

    // Next-state logic; the one counter serves debounce, timeout and gap since
    // those phases never overlap. Release and timeout outrank FRAME_DONE.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rel_cnt_next = rel_cnt_reg;
        discard_next = discard_reg;
        timeout_hit  = 1'b0;
        keep_sample  = 1'b0;
        clear_acc    = 1'b0;
        release_hit  = pen_s_reg && (rel_cnt_reg == REL_LAST);
        case (state_reg)
            IDLE: begin
                if (!pen_s_reg) begin
                    state_next = DEBOUNCE;
                    cnt_next   = '0;
                end
            end
            DEBOUNCE: begin
                if (pen_s_reg) begin
                    state_next = IDLE;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next   = START;
                    cnt_next     = '0;
                    rel_cnt_next = '0;
                    discard_next = 1'b1;
                    clear_acc    = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            START: begin
                rel_cnt_next = pen_s_reg ? rel_cnt_reg + 1'b1 : '0;
                if (release_hit) begin
                    state_next = IDLE;
                    clear_acc  = 1'b1;
                end else if (cnt_reg == TO_LAST) begin
                    state_next  = IDLE;
                    timeout_hit = 1'b1;
                    clear_acc   = 1'b1;
                end else if (FRAME_DONE) begin
                    state_next = GAP;
                    cnt_next   = '0;
                    if (discard_reg) begin
                        discard_next = 1'b0;
                    end else begin
                        keep_sample = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                rel_cnt_next = pen_s_reg ? rel_cnt_reg + 1'b1 : '0;
                if (release_hit) begin
                    state_next = IDLE;
                    clear_acc  = 1'b1;
                end else if (cnt_reg == GAP_LAST) begin
                    state_next = START;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        pen_down_next    = (state_next == START) || (state_next == GAP);
        adc_start_n_next = (state_next != START);
    end

    assign frm_full = (frm_cnt_reg == FRM_FULL);

    // Accumulators: a full set is emptied into the output the cycle after the
    // last kept frame lands; press, release and timeout drop partial sums.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_x_reg   <= '0;
            acc_y_reg   <= '0;
            frm_cnt_reg <= '0;
        end else if (frm_full || clear_acc) begin
            acc_x_reg   <= '0;
            acc_y_reg   <= '0;
            frm_cnt_reg <= '0;
        end else if (keep_sample) begin
            acc_x_reg   <= acc_x_reg + AW'(X_IN);
            acc_y_reg   <= acc_y_reg + AW'(Y_IN);
            frm_cnt_reg <= frm_cnt_reg + 1'b1;
        end
    end

    // Output register with valid/ready; independent of the sequencer so a
    // pending result survives release and timeout.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x_out_reg   <= '0;
            y_out_reg   <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= frm_full && valid_reg && !COORD_READY;
            if (frm_full) begin
                x_out_reg <= acc_x_reg[AW-1:AVG_LOG2];
                y_out_reg <= acc_y_reg[AW-1:AVG_LOG2];
                valid_reg <= 1'b1;
            end else if (valid_reg && COORD_READY) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign ADC_START_n = adc_start_n_reg;
    assign PEN_DOWN    = pen_down_reg;
    assign X_OUT       = x_out_reg;
    assign Y_OUT       = y_out_reg;
    assign COORD_VALID = valid_reg;
    assign OVERRUN     = overrun_reg;
    assign TIMEOUT_ERR = timeout_err_reg;

endmodule

// File: tb/tb_touch_sample_ctrl.sv
// Testbench for touch_sample_ctrl: table of averaging vectors, hand-written
// press/release/overrun/timeout/reset sequences, and random frame groups
// checked against an arithmetic averaging model.
`timescale 1ns/1ps
module tb_touch_sample_ctrl;

    localparam int DEB = 4;
    localparam int GAP = 8;
    localparam int TMO = 20;
    localparam int AVG = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PENIRQ_n = 1'b1;
    logic        FRAME_DONE = 1'b0;
    logic        COORD_READY = 1'b0;
    logic [11:0] X_IN = '0;
    logic [11:0] Y_IN = '0;
    logic        ADC_START_n, PEN_DOWN, COORD_VALID, OVERRUN, TIMEOUT_ERR;
    logic [11:0] X_OUT, Y_OUT;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          pending = 1'b0;
    logic [11:0] last_x = '0;
    logic [11:0] last_y = '0;

    typedef struct {
        logic [3:0][11:0] xs;
        logic [3:0][11:0] ys;
        logic [11:0]      exp_x;
        logic [11:0]      exp_y;
    } vec_t;

    vec_t vecs[4];

    always #5 CLK = ~CLK;

    touch_sample_ctrl #(
        .SYSCLK_FRQ (50000000),
        .DEB_CNT    (DEB),
        .GAP_CNT    (GAP),
        .TIMEOUT_CNT(TMO),
        .AVG_LOG2   (AVG)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PENIRQ_n   (PENIRQ_n),
        .FRAME_DONE (FRAME_DONE),
        .X_IN       (X_IN),
        .Y_IN       (Y_IN),
        .ADC_START_n(ADC_START_n),
        .PEN_DOWN   (PEN_DOWN),
        .X_OUT      (X_OUT),
        .Y_OUT      (Y_OUT),
        .COORD_VALID(COORD_VALID),
        .COORD_READY(COORD_READY),
        .OVERRUN    (OVERRUN),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Press the pen and check the exact pen-down latency (2 sync + DEB + 1).
    task automatic press(input string tag);
        repeat (3) tick();
        PENIRQ_n = 1'b0;
        repeat (DEB + 2) tick();
        chk1({tag, "_pen_down_early"}, PEN_DOWN, 1'b0);
        chk1({tag, "_adc_start_early"}, ADC_START_n, 1'b1);
        tick();
        chk1({tag, "_pen_down"}, PEN_DOWN, 1'b1);
        chk1({tag, "_adc_start"}, ADC_START_n, 1'b0);
        $display("press %s: pen_down=%0b adc_start_n=%0b", tag, PEN_DOWN, ADC_START_n);
    endtask

    // Release the pen; PEN_DOWN must drop DEB cycles after the synchronized edge.
    task automatic release_pen(input string tag);
        PENIRQ_n = 1'b1;
        repeat (DEB + 1) tick();
        chk1({tag, "_pen_down_hold"}, PEN_DOWN, 1'b1);
        tick();
        chk1({tag, "_pen_down"}, PEN_DOWN, 1'b0);
        chk1({tag, "_adc_start"}, ADC_START_n, 1'b1);
        chk1({tag, "_valid_kept"}, COORD_VALID, pending);
        $display("release %s: pen_down=%0b valid=%0b", tag, PEN_DOWN, COORD_VALID);
    endtask

    // Act as the ADC controller: wait for a frame request, return one sample.
    task automatic do_frame(input logic [11:0] x, input logic [11:0] y, input int lat);
        int waited = 0;
        while (ADC_START_n !== 1'b0 && waited < 100) begin
            tick();
            waited++;
        end
        chk1("frame_start_wait", ADC_START_n, 1'b0);
        if (ADC_START_n === 1'b0) begin
            repeat (lat) tick();
            X_IN = x;
            Y_IN = y;
            FRAME_DONE = 1'b1;
            tick();
            FRAME_DONE = 1'b0;
            X_IN = 12'($urandom);
            Y_IN = 12'($urandom);
            chk1("adc_start_after_done", ADC_START_n, 1'b1);
        end
    endtask

    // Four kept frames, then check the averaged result one edge later.
    task automatic run_group(input logic [3:0][11:0] xs, input logic [3:0][11:0] ys,
                             input logic [11:0] ex, input logic [11:0] ey, input string tag);
        bit exp_ovr;
        exp_ovr = pending;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                chk1({tag, "_no_early_valid"}, COORD_VALID, pending);
                if (pending) begin
                    chk12({tag, "_x_stable"}, X_OUT, last_x);
                    chk12({tag, "_y_stable"}, Y_OUT, last_y);
                end
            end
            do_frame(xs[i], ys[i], int'($urandom_range(0, 5)));
        end
        tick();
        chk1({tag, "_valid"}, COORD_VALID, 1'b1);
        chk12({tag, "_x_out"}, X_OUT, ex);
        chk12({tag, "_y_out"}, Y_OUT, ey);
        chk1({tag, "_overrun"}, OVERRUN, exp_ovr);
        $display("result %s: x=%0d y=%0d (exp %0d %0d) overrun=%0b", tag, X_OUT, Y_OUT, ex, ey, OVERRUN);
        pending = 1'b1;
        last_x = ex;
        last_y = ey;
    endtask

    task automatic consume(input string tag);
        COORD_READY = 1'b1;
        tick();
        COORD_READY = 1'b0;
        chk1({tag, "_valid_after_ready"}, COORD_VALID, 1'b0);
        pending = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0][11:0] rx, ry;
        int sx, sy;

        vecs[0].xs = {12'd500, 12'd400, 12'd300, 12'd200};
        vecs[0].ys = {12'd40, 12'd40, 12'd40, 12'd40};
        vecs[0].exp_x = 12'd350; vecs[0].exp_y = 12'd40;
        vecs[1].xs = {12'd2, 12'd1, 12'd1, 12'd1};
        vecs[1].ys = {12'd3, 12'd0, 12'd0, 12'd0};
        vecs[1].exp_x = 12'd1; vecs[1].exp_y = 12'd0;
        vecs[2].xs = {12'd4095, 12'd4095, 12'd4095, 12'd4095};
        vecs[2].ys = {12'd0, 12'd0, 12'd0, 12'd4095};
        vecs[2].exp_x = 12'd4095; vecs[2].exp_y = 12'd1023;
        vecs[3].xs = {12'd3, 12'd0, 12'd0, 12'd0};
        vecs[3].ys = {12'd13, 12'd12, 12'd11, 12'd10};
        vecs[3].exp_x = 12'd0; vecs[3].exp_y = 12'd11;

        // Reset values
        RST = 1'b1;
        repeat (3) tick();
        chk1("rst_adc_start_n", ADC_START_n, 1'b1);
        chk1("rst_pen_down", PEN_DOWN, 1'b0);
        chk12("rst_x_out", X_OUT, 12'd0);
        chk12("rst_y_out", Y_OUT, 12'd0);
        chk1("rst_valid", COORD_VALID, 1'b0);
        chk1("rst_overrun", OVERRUN, 1'b0);
        chk1("rst_timeout", TIMEOUT_ERR, 1'b0);
        $display("reset: adc_start_n=%0b pen_down=%0b valid=%0b", ADC_START_n, PEN_DOWN, COORD_VALID);
        RST = 1'b0;
        tick();

        // Bounce: short lows must never reach pen-down
        for (int b = 0; b < 5; b++) begin
            PENIRQ_n = 1'b0;
            repeat (3) begin
                tick();
                chk1("bounce_pen_down", PEN_DOWN, 1'b0);
                chk1("bounce_adc_start", ADC_START_n, 1'b1);
            end
            PENIRQ_n = 1'b1;
            repeat (3) begin
                tick();
                chk1("bounce_pen_down", PEN_DOWN, 1'b0);
                chk1("bounce_adc_start", ADC_START_n, 1'b1);
            end
            $display("bounce %0d: pen_down=%0b adc_start_n=%0b", b, PEN_DOWN, ADC_START_n);
        end

        // Table-driven averaging (first frame after press is dropped)
        press("press1");
        do_frame(12'd100, 12'd40, 2);
        for (int v = 0; v < 4; v++) begin
            run_group(vecs[v].xs, vecs[v].ys, vecs[v].exp_x, vecs[v].exp_y, $sformatf("vec%0d", v));
            consume($sformatf("vec%0d", v));
        end

        // Overrun: two results with no consumer
        run_group({12'd8, 12'd8, 12'd8, 12'd8}, {12'd16, 12'd16, 12'd16, 12'd16},
                  12'd8, 12'd16, "ovr_first");
        run_group({12'd1003, 12'd1002, 12'd1001, 12'd1000}, {12'd7, 12'd7, 12'd7, 12'd7},
                  12'd1001, 12'd7, "ovr_second");
        tick();
        chk1("overrun_single_pulse", OVERRUN, 1'b0);
        chk12("overrun_x_second", X_OUT, 12'd1001);
        consume("ovr");

        // Release after two kept frames: partial sum dropped, next press discards
        do_frame(12'd3000, 12'd3000, 1);
        do_frame(12'd3000, 12'd3000, 1);
        release_pen("release_mid");
        repeat (4) tick();
        chk1("release_mid_no_valid", COORD_VALID, 1'b0);
        press("press2");
        do_frame(12'd999, 12'd999, 1);
        run_group({12'd160, 12'd120, 12'd80, 12'd40}, {12'd5, 12'd4, 12'd4, 12'd4},
                  12'd100, 12'd4, "after_repress");
        consume("after_repress");

        // Random frame groups against the averaging model
        for (int r = 0; r < 12; r++) begin
            sx = 0;
            sy = 0;
            for (int i = 0; i < 4; i++) begin
                rx[i] = 12'($urandom_range(0, 4095));
                ry[i] = 12'($urandom_range(0, 4095));
                sx += int'(rx[i]);
                sy += int'(ry[i]);
            end
            run_group(rx, ry, 12'(sx / (1 << AVG)), 12'(sy / (1 << AVG)), $sformatf("rand%0d", r));
            if ($urandom_range(0, 1) == 1) consume($sformatf("rand%0d", r));
        end
        release_pen("release_end");
        repeat (4) tick();

        // Timeout: frame requested, never completed
        press("press_tmo");
        repeat (TMO - 1) tick();
        chk1("tmo_early", TIMEOUT_ERR, 1'b0);
        chk1("tmo_adc_held", ADC_START_n, 1'b0);
        tick();
        chk1("tmo_pulse", TIMEOUT_ERR, 1'b1);
        chk1("tmo_adc_start", ADC_START_n, 1'b1);
        chk1("tmo_pen_down", PEN_DOWN, 1'b0);
        chk1("tmo_valid_kept", COORD_VALID, pending);
        $display("timeout: err=%0b adc_start_n=%0b pen_down=%0b", TIMEOUT_ERR, ADC_START_n, PEN_DOWN);
        PENIRQ_n = 1'b1;
        tick();
        chk1("tmo_single_pulse", TIMEOUT_ERR, 1'b0);
        repeat (6) tick();

        // Asynchronous reset while a frame is requested
        press("press_rst");
        #3;
        RST = 1'b1;
        #1;
        chk1("async_rst_adc_start", ADC_START_n, 1'b1);
        chk1("async_rst_pen_down", PEN_DOWN, 1'b0);
        chk1("async_rst_valid", COORD_VALID, 1'b0);
        $display("async reset: adc_start_n=%0b pen_down=%0b", ADC_START_n, PEN_DOWN);
        PENIRQ_n = 1'b1;
        tick();
        RST = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
